// File: rtl/com_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// com_pkg : dispatcher states, register map and STATUS layout.
// Rev 1.0
// ------------------------------------------------------------------
package com_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } disp_state_e;

  localparam logic REG_PUSH   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int STAT_OVF   = 15;
  localparam int STAT_TMO   = 14;
  localparam int STAT_FULL  = 13;
  localparam int STAT_EMPTY = 12;
  localparam int STAT_CNT_W = 7;

  function automatic logic [15:0] status_word(input logic       ovf,
                                              input logic       tmo,
                                              input logic       full,
                                              input logic       empty,
                                              input logic [6:0] cnt);
    logic [15:0] w;
    w                   = '0;
    w[STAT_OVF]         = ovf;
    w[STAT_TMO]         = tmo;
    w[STAT_FULL]        = full;
    w[STAT_EMPTY]       = empty;
    w[STAT_CNT_W-1:0]   = cnt;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/com_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// com_fifo : single-clock 16-bit FIFO with show-ahead head output.
// Rev 1.0
// ------------------------------------------------------------------
module com_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [15:0]   din_i,
  input  logic          pop_i,
  output logic [15:0]   head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          w_push, w_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_pop  = pop_i & ~empty_o;
  assign w_push = push_i & (~full_o | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/com_cmd_queue.sv
`default_nettype none
// ------------------------------------------------------------------
// com_cmd_queue : J1 command FIFO feeding the UART transmitter.
// Define COM_CMDQ_TIMEOUT_EN for the bussy-ack timeout.  Rev 1.0
// ------------------------------------------------------------------
module com_cmd_queue
  import com_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic        rd,
  input  logic        addr,
  input  logic [15:0] d_in,
  output logic [15:0] d_out,
  output logic [7:0]  datos,
  output logic [7:0]  comando,
  output logic        start_j1,
  input  logic        bussy,
  output logic        irq_empty
);

  disp_state_e state_q;
  logic [15:0] d_out_q;
  logic [7:0]  datos_q, comando_q;
  logic        start_j1_q, ovf_q;
  logic [15:0] w_head;
  logic [AW:0] w_count;
  logic        w_full, w_empty, w_push_req, w_ctl_wr, w_pop, w_push, w_tmo, w_tmo_hit;

  assign w_push_req = cs & wr & (addr == REG_PUSH);
  assign w_ctl_wr   = cs & wr & (addr == REG_STATUS);
  assign w_pop      = (state_q == ST_IDLE) & ~w_empty & ~bussy;
  assign w_push     = w_push_req & (~w_full | w_pop);

  com_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (w_push),
    .din_i   (d_in),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

`ifdef COM_CMDQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_q;

  assign w_tmo_hit = (state_q == ST_WAIT_ACK) & ~bussy &
                     (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
  assign w_tmo     = tmo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      if (state_q == ST_LOAD)
        tmo_cnt_q <= '0;
      else if ((state_q == ST_WAIT_ACK) && !bussy)
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (w_tmo_hit)
        tmo_q <= 1'b1;
      else if (w_ctl_wr && d_in[14])
        tmo_q <= 1'b0;
    end
  end
`else
  logic w_unused_tmo_cfg;
  assign w_unused_tmo_cfg = |TIMEOUT_CYC;
  assign w_tmo_hit        = 1'b0;
  assign w_tmo            = 1'b0;
`endif

  // datos/comando load only on pop, so they stay stable for the whole transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      start_j1_q <= 1'b0;
      datos_q    <= '0;
      comando_q  <= '0;
    end else begin
      start_j1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_pop) begin
            datos_q    <= w_head[7:0];
            comando_q  <= w_head[15:8];
            start_j1_q <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD:      state_q <= ST_WAIT_ACK;
        ST_WAIT_ACK: begin
          if (bussy)          state_q <= ST_WAIT_DONE;
          else if (w_tmo_hit) state_q <= ST_IDLE;
        end
        ST_WAIT_DONE: if (!bussy) state_q <= ST_IDLE;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q   <= 1'b0;
      d_out_q <= '0;
    end else begin
      if (w_push_req && !w_push)
        ovf_q <= 1'b1;
      else if (w_ctl_wr && d_in[15])
        ovf_q <= 1'b0;
      if (cs && rd)
        d_out_q <= (addr == REG_STATUS)
                 ? status_word(ovf_q, w_tmo, w_full, w_empty, 7'(w_count))
                 : w_head;
    end
  end

  assign d_out     = d_out_q;
  assign datos     = datos_q;
  assign comando   = comando_q;
  assign start_j1  = start_j1_q;
  assign irq_empty = w_empty & (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_com_cmd_queue.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_com_cmd_queue : scoreboard bench for the command queue.
// Rev 1.0
// ------------------------------------------------------------------
module tb_com_cmd_queue;

  localparam int DEPTH = 8;
`ifdef COM_CMDQ_TIMEOUT_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 1000000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0, wr = 1'b0, rd = 1'b0, addr = 1'b0;
  logic [15:0] d_in = '0;
  logic [15:0] d_out;
  logic [7:0]  datos, comando;
  logic        start_j1, irq_empty;
  logic        bussy;
  logic        bussy_model = 1'b0;
  logic        bussy_hold  = 1'b0;
  assign bussy = bussy_model | bussy_hold;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int stab_err = 0;
  bit model_en = 1'b0;
  int model_len = 5;
  logic [15:0] sb_q[$];
  logic [15:0] obs_q[$];
  int          obs_cyc_q[$];
  int          fall_q[$];
  logic [15:0] held = '0;

  com_cmd_queue #(.DEPTH(DEPTH), .AW(3), .TIMEOUT_CYC(TB_TMO)) dut (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
    .d_in(d_in), .d_out(d_out), .datos(datos), .comando(comando),
    .start_j1(start_j1), .bussy(bussy), .irq_empty(irq_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: records issued entries and watches output stability while busy.
  initial forever begin
    @(negedge clk);
    if (start_j1) begin
      obs_q.push_back({comando, datos});
      obs_cyc_q.push_back(cyc);
      pulse_cnt = pulse_cnt + 1;
      held = {comando, datos};
    end else if (bussy && ({comando, datos} !== held)) begin
      stab_err = stab_err + 1;
    end
  end

  // Transmitter model: bussy rises right after start_j1 and stays up model_len cycles.
  initial forever begin
    @(negedge clk);
    if (model_en && start_j1) begin
      bussy_model = 1'b1;
      repeat (model_len) @(negedge clk);
      bussy_model = 1'b0;
      fall_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic a, input logic [15:0] v);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic a, output logic [15:0] v);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    v = d_out;
  endtask

  task automatic push(input logic [15:0] v, input bit accept);
    bus_write(1'b0, v);
    if (accept) sb_q.push_back(v);
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obs_q.size() >= n) break;
      @(negedge clk);
    end
    if (obs_q.size() >= n) ok = 1'b1;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc_q.delete();
    fall_q.delete();
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({start_j1, datos, comando, d_out} !== 33'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", {start_j1, datos, comando, d_out}, 33'h0);
    end
    checks++;
    if (irq_empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_irq_empty: got %b expected 1", irq_empty);
    end
    rst = 1'b1;
    @(negedge clk);
    bus_read(1'b1, v);
    checks++;
    if (v !== 16'h1000) begin
      failures++;
      $display("FAIL reset_status: got %h expected 1000", v);
    end
  endtask

  task automatic test_single();
    int p0;
    logic [15:0] exp;
    model_en = 1'b1; model_len = 5;
    clear_obs();
    p0 = pulse_cnt;
    push(16'h0341, 1'b1);
    checks++;
    if (start_j1 !== 1'b0) begin
      failures++;
      $display("FAIL single_early: start_j1 got %b expected 0", start_j1);
    end
    @(negedge clk);
    checks++;
    if (start_j1 !== 1'b1) begin
      failures++;
      $display("FAIL single_latency: start_j1 got %b expected 1", start_j1);
    end
    exp = sb_q.pop_front();
    checks++;
    if ({comando, datos} !== exp) begin
      failures++;
      $display("FAIL single_payload: got %h expected %h", {comando, datos}, exp);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (pulse_cnt - p0 != 1) begin
      failures++;
      $display("FAIL single_pulse_count: got %0d expected 1", pulse_cnt - p0);
    end
    checks++;
    if (irq_empty !== 1'b1) begin
      failures++;
      $display("FAIL single_irq_empty: got %b expected 1", irq_empty);
    end
  endtask

  task automatic test_back_to_back();
    int p0, s0;
    bit ok;
    logic [15:0] exp;
    model_en = 1'b1; model_len = 20;
    clear_obs();
    p0 = pulse_cnt; s0 = stab_err;
    push(16'h1122, 1'b1);
    push(16'h3344, 1'b1);
    push(16'h5566, 1'b1);
    wait_obs(3, 300, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL b2b_timeout: got %0d pulses expected 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp = sb_q.pop_front();
        checks++;
        if (obs_q[i] !== exp) begin
          failures++;
          $display("FAIL b2b_order[%0d]: got %h expected %h", i, obs_q[i], exp);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (fall_q.size() < i || (obs_cyc_q[i] - fall_q[i-1]) < 2) begin
          failures++;
          $display("FAIL b2b_gap[%0d]: got %0d cycles expected >=2", i,
                   (fall_q.size() < i) ? -1 : obs_cyc_q[i] - fall_q[i-1]);
        end
      end
    end
    repeat (30) @(negedge clk);
    checks++;
    if (stab_err != s0) begin
      failures++;
      $display("FAIL b2b_stable: got %0d changes expected 0", stab_err - s0);
    end
    checks++;
    if (pulse_cnt - p0 != 3) begin
      failures++;
      $display("FAIL b2b_pulse_count: got %0d expected 3", pulse_cnt - p0);
    end
  endtask

  task automatic test_overflow_head();
    logic [15:0] v, exp;
    int p0;
    bit ok;
    model_en = 1'b0;
    bussy_hold = 1'b1;
    push(16'h05AA, 1'b1);
    for (int i = 1; i < DEPTH; i++) push(16'h0100 + 16'(i), 1'b1);
    push(16'h0EEE, 1'b0);
    bus_read(1'b1, v);
    checks++;
    if (v !== 16'hA008) begin
      failures++;
      $display("FAIL ovf_status: got %h expected a008", v);
    end
    bus_read(1'b0, v);
    checks++;
    if (v !== 16'h05AA) begin
      failures++;
      $display("FAIL head_read: got %h expected 05aa", v);
    end
    bus_read(1'b1, v);
    checks++;
    if (v !== 16'hA008) begin
      failures++;
      $display("FAIL head_no_pop: got %h expected a008", v);
    end
    checks++;
    if (irq_empty !== 1'b0) begin
      failures++;
      $display("FAIL ovf_irq_empty: got %b expected 0", irq_empty);
    end
    bus_write(1'b1, 16'h8000);
    bus_read(1'b1, v);
    checks++;
    if (v !== 16'h2008) begin
      failures++;
      $display("FAIL ovf_clear: got %h expected 2008", v);
    end
    clear_obs();
    p0 = pulse_cnt;
    model_len = 3;
    model_en = 1'b1;
    bussy_hold = 1'b0;
    wait_obs(DEPTH, 400, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pulses expected %0d", obs_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        exp = sb_q.pop_front();
        checks++;
        if (obs_q[i] !== exp) begin
          failures++;
          $display("FAIL drain_order[%0d]: got %h expected %h", i, obs_q[i], exp);
        end
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (pulse_cnt - p0 != DEPTH) begin
      failures++;
      $display("FAIL drain_count: got %0d expected %0d", pulse_cnt - p0, DEPTH);
    end
    sb_q.delete();
  endtask

  task automatic test_reset_midflight();
    logic [15:0] v;
    int p0;
    bit ok;
    model_en = 1'b1; model_len = 20;
    clear_obs();
    for (int i = 1; i <= 5; i++) push(16'h2000 + 16'(i), 1'b1);
    wait_obs(1, 50, ok);
    bus_read(1'b1, v);
    checks++;
    if (!ok || v !== 16'h0004) begin
      failures++;
      $display("FAIL mid_status: got %h (pulse %b) expected 0004", v, ok);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({start_j1, datos, comando, d_out, irq_empty} !== {17'h0, 16'h0, 1'b1}) begin
      failures++;
      $display("FAIL mid_async_reset: got %h expected %h",
               {start_j1, datos, comando, d_out, irq_empty}, {17'h0, 16'h0, 1'b1});
    end
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    p0 = pulse_cnt;
    bus_read(1'b1, v);
    checks++;
    if (v !== 16'h1000) begin
      failures++;
      $display("FAIL mid_post_status: got %h expected 1000", v);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (pulse_cnt != p0) begin
      failures++;
      $display("FAIL mid_no_reissue: got %0d pulses expected 0", pulse_cnt - p0);
    end
  endtask

`ifdef COM_CMDQ_TIMEOUT_EN
  task automatic test_timeout();
    logic [15:0] v, exp;
    bit ok;
    model_en = 1'b0;
    bussy_hold = 1'b0;
    clear_obs();
    push(16'h0A01, 1'b1);
    push(16'h0A02, 1'b1);
    wait_obs(2, 100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL tmo_reissue: got %0d pulses expected 2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp = sb_q.pop_front();
        checks++;
        if (obs_q[i] !== exp) begin
          failures++;
          $display("FAIL tmo_order[%0d]: got %h expected %h", i, obs_q[i], exp);
        end
      end
      checks++;
      if (obs_cyc_q[1] - obs_cyc_q[0] != 18) begin
        failures++;
        $display("FAIL tmo_gap: got %0d expected 18", obs_cyc_q[1] - obs_cyc_q[0]);
      end
    end
    repeat (25) @(negedge clk);
    bus_read(1'b1, v);
    checks++;
    if (v !== 16'h5000) begin
      failures++;
      $display("FAIL tmo_status: got %h expected 5000", v);
    end
    bus_write(1'b1, 16'h4000);
    bus_read(1'b1, v);
    checks++;
    if (v !== 16'h1000) begin
      failures++;
      $display("FAIL tmo_clear: got %h expected 1000", v);
    end
  endtask
`else
  task automatic test_no_timeout();
    logic [15:0] v, exp;
    bit ok;
    model_en = 1'b0;
    bussy_hold = 1'b0;
    clear_obs();
    push(16'h0B01, 1'b1);
    wait_obs(1, 20, ok);
    exp = sb_q.pop_front();
    checks++;
    if (!ok || obs_q[0] !== exp) begin
      failures++;
      $display("FAIL notmo_issue: got %h (seen %b) expected %h", ok ? obs_q[0] : 16'h0, ok, exp);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (irq_empty !== 1'b0) begin
      failures++;
      $display("FAIL notmo_waiting: irq_empty got %b expected 0", irq_empty);
    end
    bus_read(1'b1, v);
    checks++;
    if (v !== 16'h1000) begin
      failures++;
      $display("FAIL notmo_status: got %h expected 1000", v);
    end
    bussy_hold = 1'b1;
    repeat (3) @(negedge clk);
    bussy_hold = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (irq_empty !== 1'b1) begin
      failures++;
      $display("FAIL notmo_recover: irq_empty got %b expected 1", irq_empty);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow_head();
    test_reset_midflight();
`ifdef COM_CMDQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/com_cmd_queue.md
Name: com_cmd_queue

Overview:
- Upstream feeder for the UART command/data transmitter top level.
- Accepts {comando, datos} pairs from the J1 peripheral bus and buffers them in a FIFO.
- Issues each pair to the transmitter as a one-cycle start_j1 pulse, with datos/comando held stable.
- Paces issue using the transmitter's bussy flag, so firmware never has to poll bussy itself.

Parameters:
- DEPTH, 8, FIFO entries (power of two, 2..64)
- AW, 3, log2(DEPTH)
- TIMEOUT_CYC, 1000000, max cycles to wait for bussy to rise after a start pulse (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- cs  in  1  peripheral select from J1 bus decoder
- wr  in  1  bus write strobe, qualified by cs
- rd  in  1  bus read strobe, qualified by cs
- addr  in  1  register select: 0=PUSH, 1=STATUS
- d_in  in  16  write data
- d_out  out  16  read data, registered
- datos  out  8  data byte to transmitter
- comando  out  8  command byte to transmitter
- start_j1  out  1  one-cycle launch pulse to transmitter
- bussy  in  1  transmitter busy, high while a transfer runs
- irq_empty  out  1  level, high when FIFO empty and dispatcher in IDLE

Behaviour:
- Reset (rst=0, async):
  - FIFO pointers/count cleared; FSM to IDLE.
  - datos=0, comando=0, start_j1=0, d_out=0, sticky flags cleared.
  - irq_empty=1 after reset.
- Push, write addr 0: entry = {comando=d_in[15:8], datos=d_in[7:0]}.
  - Accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise dropped and sticky OVF set.
- Write addr 1: d_in[15]=1 clears OVF; d_in[14]=1 clears TMO. Other bits ignored.
- Read: d_out updated the cycle after cs&rd; holds its value otherwise.
  - addr 1 returns {OVF, TMO, full, empty, 5'b0, count[6:0]}; count is zero-extended.
  - addr 0 returns {comando, datos} of the FIFO head, without popping.
- Dispatcher FSM:
  - IDLE: when FIFO non-empty and bussy=0 → pop head into datos/comando regs; go LOAD.
  - LOAD: start_j1=1 for exactly this cycle; go WAIT_ACK.
  - WAIT_ACK: stay until bussy=1; then go WAIT_DONE.
  - WAIT_DONE: stay until bussy=0; then go IDLE.
- Latency: push in cycle N into an empty FIFO with FSM idle and bussy=0 → start_j1 high in cycle N+2.
- datos/comando change only on pop, so they are stable from LOAD until the next pop.
- Back-to-back entries: next start_j1 comes no earlier than 2 cycles after bussy falls.
- If bussy is already high in IDLE (transmitter busy for another reason), the dispatcher waits.
- Pointers wrap modulo DEPTH; count is AW+1 bits.
- Simultaneous push and pop on an empty FIFO: not possible, since a pop requires non-empty in the prior cycle.
- Reset mid-transfer: all queued entries are discarded; start_j1 is never re-issued after reset.

Optional Feature:
- Macro: COM_CMDQ_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_ACK.
  - After TIMEOUT_CYC cycles without bussy=1, FSM returns to IDLE, sticky TMO is set, and the entry is dropped.
  - The counter clears on entry to WAIT_ACK.
- Undefined:
  - No counter; WAIT_ACK waits indefinitely.
  - TMO reads 0.

Decomposition:
- Shared package com_pkg:
  - FSM state encoding (IDLE, LOAD, WAIT_ACK, WAIT_DONE).
  - Register address constants: REG_PUSH=0, REG_STATUS=1.
  - STATUS bit positions.
- Sub-module com_fifo:
  - Synchronous single-clock FIFO, 16-bit wide, parameterised DEPTH.
  - Provides push/pop, full/empty, count.
  - Async active-low reset.

Test Plan:
- Single push d_in=16'h0341 with bussy=0 → start_j1 pulse 2 cycles later; comando=8'h03, datos=8'h41; no second pulse.
- Push 3 entries; model bussy high for 20 cycles after each start → 3 pulses in order; each pulse ≥2 cycles after the previous bussy fall; datos/comando constant while bussy=1.
- Hold bussy=1 and push DEPTH+1 entries → last entry dropped; STATUS reads OVF=1, full=1, count=8. Write 16'h8000 to addr 1 → OVF=0.
- Assert rst=0 with 4 entries queued, mid WAIT_DONE → all outputs go to reset values immediately; STATUS reads empty=1, count=0; no start_j1 after release.
- With COM_CMDQ_TIMEOUT_EN, TIMEOUT_CYC=16, bussy stuck 0 → FSM leaves WAIT_ACK after 16 cycles; TMO=1; next entry is issued.
- Read addr 0 with head {8'h05, 8'hAA} → d_out=16'h05AA one cycle later; count unchanged.
